// File: rtl/prga_prog_pkg.sv
// Shared types and register-map constants for the PRGA bitstream loader.
package prga_prog_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RST  = 3'd1,
        ST_LOAD = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_e;

    localparam logic [1:0] REG_CTRL  = 2'd0;
    localparam logic [1:0] REG_LEN   = 2'd1;
    localparam logic [1:0] REG_DATA  = 2'd2;
    localparam logic [1:0] REG_COUNT = 2'd3;

    localparam int CTRL_START = 0;
    localparam int CTRL_ABORT = 1;

    localparam int STAT_ERR       = 31;
    localparam int STAT_DONE      = 30;
    localparam int STAT_STATE_LSB = 28;
    localparam int STAT_LEVEL_LSB = 16;
    localparam int STAT_LEVEL_W   = 12;

    // The status field is only two bits wide; DONE and ERR share code 3
    // and are told apart by the done/err bits next to it.
    function automatic logic [1:0] state_code(state_e s);
        case (s)
            ST_IDLE: return 2'd0;
            ST_RST:  return 2'd1;
            ST_LOAD: return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/prga_prog_fifo.sv
// Synchronous word FIFO; push and pop may coincide, flush wins over both.
module prga_prog_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign level   = wr_ptr - rd_ptr;
    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign dout    = mem[rd_ptr[AW-1:0]];
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/prga_prog_loader.sv
// Wishbone-fed bitstream loader: buffers words and streams them in PROG_W-bit
// chunks onto the PRGA programming port.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start; DATA writes preload the FIFO
// RST     | prog_rst held high for RST_CYCLES cycles
// LOAD    | shifting chunks out, stalling while the FIFO is dry
// DONE    | LEN chunks emitted; prog_done/irq held until start or abort
// ERR     | start seen with LEN==0; err/irq held until abort
module prga_prog_loader
    import prga_prog_pkg::*;
#(
    parameter int WORD_W     = 32,
    parameter int PROG_W     = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 24,
    parameter int RST_CYCLES = 4
) (
    input  logic              prog_clk,
    input  logic              prog_rst_n,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [WORD_W-1:0] wbs_dat_i,
    input  logic [3:0]        wbs_sel_i,
    output logic              wbs_ack_o,
    output logic [WORD_W-1:0] wbs_dat_o,
    output logic              prog_rst,
    output logic              prog_we,
    output logic [PROG_W-1:0] prog_din,
    output logic              prog_done,
    output logic              irq
);

    localparam int CPW    = WORD_W / PROG_W;
    localparam int REM_W  = $clog2(CPW + 1);
    localparam int RST_CW = $clog2(RST_CYCLES + 1);
    localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;

    state_e              state_q, state_d;
    logic                ack_q;
    logic [WORD_W-1:0]   dat_q;
    logic [CNT_W-1:0]    len_q;
    logic [CNT_W-1:0]    count_q;
    logic [RST_CW-1:0]   rst_cnt_q;
    logic [WORD_W-1:0]   sreg_q;
    logic [REM_W-1:0]    rem_q;
    logic                prog_we_q;
    logic [PROG_W-1:0]   prog_din_q;
    logic                done_q;

    logic [1:0]          adr_idx;
    logic                req, ctrl_wr, data_wr, len_wr;
    logic                start_req, abort_req;
    logic                accept;
    logic                emit, last_chunk, enter_rst;
    logic [WORD_W-1:0]   cur_word;
    logic [WORD_W-1:0]   rd_val;
    logic                err;

    logic                fifo_push, fifo_pop, fifo_flush;
    logic                fifo_full, fifo_empty;
    logic [WORD_W-1:0]   fifo_dout;
    logic [LVL_W-1:0]    fifo_level;

    logic                unused_bits;
    assign unused_bits = ^{wbs_sel_i, wbs_adr_i[31:4], wbs_adr_i[1:0]};

    prga_prog_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (prog_clk),
        .rst_n (prog_rst_n),
        .push  (fifo_push),
        .din   (wbs_dat_i),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Start/abort are decoded from the raw request rather than from accept so
    // that pop -> accept never loops back through the abort path.
    assign adr_idx   = wbs_adr_i[3:2];
    assign req       = wbs_cyc_i & wbs_stb_i & ~ack_q;
    assign ctrl_wr   = req & wbs_we_i & (adr_idx == REG_CTRL);
    assign data_wr   = req & wbs_we_i & (adr_idx == REG_DATA);
    assign len_wr    = req & wbs_we_i & (adr_idx == REG_LEN);
    assign abort_req = ctrl_wr & wbs_dat_i[CTRL_ABORT];
    assign start_req = ctrl_wr & wbs_dat_i[CTRL_START] & ~wbs_dat_i[CTRL_ABORT];

    // With no chunk left in the shift register the head word is emitted directly,
    // so the word after the last chunk never costs a bubble.
    assign cur_word   = (rem_q != '0) ? sreg_q : fifo_dout;
    assign emit       = (state_q == ST_LOAD) & ((rem_q != '0) | ~fifo_empty) & ~abort_req;
    assign fifo_pop   = emit & (rem_q == '0);
    assign last_chunk = emit & ((count_q + CNT_W'(1)) == len_q);
    assign fifo_flush = abort_req | last_chunk;
    assign accept     = req & (~data_wr | ~fifo_full | fifo_pop);
    assign fifo_push  = accept & data_wr;
    assign enter_rst  = (state_d == ST_RST) & (state_q != ST_RST);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: if (start_req) state_d = (len_q == '0) ? ST_ERR : ST_RST;
            ST_RST:           if (rst_cnt_q == '0) state_d = ST_LOAD;
            ST_LOAD:          if (last_chunk) state_d = ST_DONE;
            default:          state_d = state_q;
        endcase
        if (abort_req) state_d = ST_IDLE;
    end

    assign err = (state_q == ST_ERR);

    always_comb begin
        rd_val = '0;
        case (adr_idx)
            REG_CTRL: begin
                rd_val[STAT_ERR]                            = err;
                rd_val[STAT_DONE]                           = done_q;
                rd_val[STAT_STATE_LSB +: 2]                 = state_code(state_q);
                rd_val[STAT_LEVEL_LSB +: STAT_LEVEL_W]      = STAT_LEVEL_W'(fifo_level);
            end
            REG_LEN:   rd_val = WORD_W'(len_q);
            REG_COUNT: rd_val = WORD_W'(count_q);
            default:   rd_val = '0;
        endcase
    end

    always_ff @(posedge prog_clk) begin
        if (!prog_rst_n) begin
            state_q    <= ST_IDLE;
            ack_q      <= 1'b0;
            dat_q      <= '0;
            len_q      <= '0;
            count_q    <= '0;
            rst_cnt_q  <= '0;
            sreg_q     <= '0;
            rem_q      <= '0;
            prog_we_q  <= 1'b0;
            prog_din_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= accept;
            dat_q   <= (accept && !wbs_we_i) ? rd_val : '0;
            if (len_wr) len_q <= wbs_dat_i[CNT_W-1:0];

            if (enter_rst) begin
                rst_cnt_q <= RST_CW'(RST_CYCLES - 1);
                count_q   <= '0;
            end else if (state_q == ST_RST && rst_cnt_q != '0) begin
                rst_cnt_q <= rst_cnt_q - RST_CW'(1);
            end

            prog_we_q  <= emit;
            prog_din_q <= emit ? cur_word[WORD_W-1 -: PROG_W] : '0;
            if (emit) begin
                count_q <= count_q + CNT_W'(1);
                if (rem_q != '0) begin
                    sreg_q <= sreg_q << PROG_W;
                    rem_q  <= rem_q - REM_W'(1);
                end else begin
                    sreg_q <= fifo_dout << PROG_W;
                    rem_q  <= REM_W'(CPW - 1);
                end
            end
            // Residual chunks of the current word are dropped with the FIFO.
            if (fifo_flush || enter_rst) rem_q <= '0;

            done_q <= (state_q == ST_DONE) && (state_d == ST_DONE);
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign prog_rst  = (state_q == ST_RST);
    assign prog_we   = prog_we_q;
    assign prog_din  = prog_din_q;
    assign prog_done = done_q;
    assign irq       = done_q | err;

endmodule

// File: tb/tb_prga_prog_loader.sv
// Self-checking bench for prga_prog_loader: register table, directed
// sequences and randomized bitstreams against a chunk-stream model.
module tb_prga_prog_loader;

    localparam int PW  = 1;
    localparam int CPW = 32 / PW;

    localparam logic [1:0] A_CTRL  = 2'd0;
    localparam logic [1:0] A_LEN   = 2'd1;
    localparam logic [1:0] A_DATA  = 2'd2;
    localparam logic [1:0] A_COUNT = 2'd3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cyc, stb, we;
    logic [31:0]   adr, dat_i;
    logic [3:0]    sel;
    logic          ack;
    logic [31:0]   dat_o;
    logic          prog_rst, prog_we, prog_done, irq;
    logic [PW-1:0] prog_din;

    prga_prog_loader #(
        .WORD_W     (32),
        .PROG_W     (PW),
        .FIFO_DEPTH (4),
        .CNT_W      (24),
        .RST_CYCLES (4)
    ) dut (
        .prog_clk   (clk),
        .prog_rst_n (rst_n),
        .wbs_cyc_i  (cyc),
        .wbs_stb_i  (stb),
        .wbs_we_i   (we),
        .wbs_adr_i  (adr),
        .wbs_dat_i  (dat_i),
        .wbs_sel_i  (sel),
        .wbs_ack_o  (ack),
        .wbs_dat_o  (dat_o),
        .prog_rst   (prog_rst),
        .prog_we    (prog_we),
        .prog_din   (prog_din),
        .prog_done  (prog_done),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    int cyc_n = 0;
    always @(posedge clk) cyc_n++;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] chunks[$];
    int          we_cyc[$];
    int          rst_obs;
    int          done_cyc;
    logic [31:0] words_q[$];

    always @(negedge clk) begin
        if (prog_we) begin
            chunks.push_back(32'(prog_din));
            we_cyc.push_back(cyc_n);
        end
        if (prog_rst) rst_obs++;
        if (prog_done && done_cyc < 0) done_cyc = cyc_n;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wb_xfer(input logic [1:0] idx, input logic w, input logic [31:0] d,
                           output logic [31:0] q, output int ack_at);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = {28'h0, idx, 2'b00}; dat_i = d;
        ack_at = -1;
        q = '0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (ack) begin
                q = dat_o;
                ack_at = cyc_n;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        if (ack_at < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wb_ack_timeout: no ack within 400 cycles for reg %0d", idx);
        end
    endtask

    task automatic wr(input logic [1:0] idx, input logic [31:0] d);
        logic [31:0] q;
        int a;
        wb_xfer(idx, 1'b1, d, q, a);
    endtask

    task automatic rd(input logic [1:0] idx, output logic [31:0] q);
        int a;
        wb_xfer(idx, 1'b0, 32'h0, q, a);
    endtask

    task automatic clear_mon();
        chunks.delete();
        we_cyc.delete();
        rst_obs = 0;
        done_cyc = -1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_chunks(input int n, input string name);
        for (int i = 0; i < 3000; i++) begin
            if (chunks.size() >= n) break;
            @(posedge clk); #1;
        end
        chk(name, 32'(chunks.size() >= n), 32'd1);
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 3000; i++) begin
            if (prog_done) break;
            @(posedge clk); #1;
        end
        chk(name, 32'(prog_done), 32'd1);
    endtask

    // Reference: the bitstream is the words concatenated MSB-first, cut into
    // PW-bit chunks, truncated to LEN chunks.
    function automatic logic [31:0] exp_chunk(input int i);
        longint unsigned w;
        longint unsigned m;
        int c;
        w = 64'(words_q[i / CPW]);
        c = i % CPW;
        m = (64'd1 << PW) - 64'd1;
        return 32'((w >> (32 - PW * (c + 1))) & m);
    endfunction

    function automatic int gaps();
        int g = 0;
        for (int i = 1; i < we_cyc.size(); i++)
            if (we_cyc[i] != we_cyc[i-1] + 1) g++;
        return g;
    endfunction

    task automatic check_stream(input string name, input int len);
        int errs = 0;
        int n;
        chk({name, "_len"}, chunks.size(), len);
        n = (chunks.size() < len) ? chunks.size() : len;
        for (int i = 0; i < n; i++)
            if (chunks[i] !== exp_chunk(i)) errs++;
        chk({name, "_data"}, errs, 0);
    endtask

    typedef struct {
        logic [1:0]  idx;
        logic        w;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[16];

    initial begin
        logic [31:0] q;
        int          a5;
        int          a;
        int          n, len;

        vecs[0]  = '{A_LEN,   1'b1, 32'd5,        32'h0};
        vecs[1]  = '{A_LEN,   1'b0, 32'h0,        32'd5};
        vecs[2]  = '{A_LEN,   1'b1, 32'hFFFFFFFF, 32'h0};
        vecs[3]  = '{A_LEN,   1'b0, 32'h0,        32'h00FFFFFF};
        vecs[4]  = '{A_COUNT, 1'b0, 32'h0,        32'h0};
        vecs[5]  = '{A_DATA,  1'b0, 32'h0,        32'h0};
        vecs[6]  = '{A_CTRL,  1'b0, 32'h0,        32'h0};
        vecs[7]  = '{A_DATA,  1'b1, 32'h12345678, 32'h0};
        vecs[8]  = '{A_CTRL,  1'b0, 32'h0,        32'h0001_0000};
        vecs[9]  = '{A_DATA,  1'b1, 32'h9ABCDEF0, 32'h0};
        vecs[10] = '{A_CTRL,  1'b0, 32'h0,        32'h0002_0000};
        vecs[11] = '{A_DATA,  1'b0, 32'h0,        32'h0};
        vecs[12] = '{A_CTRL,  1'b1, 32'h2,        32'h0};
        vecs[13] = '{A_CTRL,  1'b0, 32'h0,        32'h0};
        vecs[14] = '{A_CTRL,  1'b1, 32'h3,        32'h0};
        vecs[15] = '{A_CTRL,  1'b0, 32'h0,        32'h0};

        cyc = 0; stb = 0; we = 0; adr = 0; dat_i = 0; sel = 4'hF;
        rst_n = 1'b0;
        clear_mon();
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        wait_cycles(1);
        chk("reset_outputs", 32'({ack, prog_rst, prog_we, prog_done, irq, prog_din}), 32'h0);
        chk("reset_dat_o", dat_o, 32'h0);

        for (int i = 0; i < 16; i++) begin
            if (vecs[i].w) begin
                wr(vecs[i].idx, vecs[i].wdata);
            end else begin
                rd(vecs[i].idx, q);
                chk($sformatf("table_%0d", i), q, vecs[i].exp);
            end
        end

        // Two words, LEN=40: all of word 1, top byte of word 2.
        wr(A_LEN, 32'd40);
        words_q = '{32'hA5A50000, 32'hFF000000};
        clear_mon();
        wr(A_DATA, words_q[0]);
        wr(A_DATA, words_q[1]);
        wr(A_CTRL, 32'h1);
        wait_done("t1_done");
        wait_cycles(10);
        check_stream("t1", 40);
        chk("t1_rst_cycles", rst_obs, 4);
        chk("t1_gaps", gaps(), 0);
        chk("t1_done_after_last_we", done_cyc,
            (we_cyc.size() > 0) ? we_cyc[we_cyc.size()-1] + 1 : -100);
        chk("t1_irq", 32'(irq), 32'd1);
        rd(A_COUNT, q);
        chk("t1_count", q, 32'd40);
        rd(A_CTRL, q);
        chk("t1_ctrl", q & 32'hCFFF_FFFF, 32'h4000_0000);

        // Six words into a 4-deep FIFO: the 5th write waits for the first pop.
        wr(A_CTRL, 32'h2);
        wr(A_LEN, 32'(6 * CPW));
        words_q.delete();
        for (int i = 0; i < 6; i++) words_q.push_back($urandom);
        clear_mon();
        for (int i = 0; i < 4; i++) wr(A_DATA, words_q[i]);
        wr(A_CTRL, 32'h1);
        wb_xfer(A_DATA, 1'b1, words_q[4], q, a5);
        wr(A_DATA, words_q[5]);
        wait_done("t2_done");
        wait_cycles(5);
        check_stream("t2", 6 * CPW);
        chk("t2_gaps", gaps(), 0);
        chk("t2_ack5_at_first_pop", a5, (we_cyc.size() > 0) ? we_cyc[0] : -100);

        // One word then a late second word: stall without error, then resume.
        wr(A_CTRL, 32'h2);
        wr(A_LEN, 32'(2 * CPW));
        words_q = '{$urandom, $urandom};
        clear_mon();
        wr(A_DATA, words_q[0]);
        wr(A_CTRL, 32'h1);
        wait_chunks(CPW, "t3_first_word");
        wait_cycles(10);
        chk("t3_stalled_count", chunks.size(), CPW);
        chk("t3_stall_we", 32'(prog_we), 32'd0);
        chk("t3_stall_no_err", 32'(irq), 32'd0);
        wr(A_DATA, words_q[1]);
        wait_done("t3_done");
        wait_cycles(3);
        check_stream("t3", 2 * CPW);
        rd(A_COUNT, q);
        chk("t3_count", q, 32'(2 * CPW));

        // LEN=0 start goes to ERR; start is then ignored until abort.
        wr(A_CTRL, 32'h2);
        wr(A_LEN, 32'd0);
        wr(A_CTRL, 32'h1);
        rd(A_CTRL, q);
        chk("t4_err_bit", 32'(q[31]), 32'd1);
        chk("t4_done_bit", 32'(q[30]), 32'd0);
        chk("t4_irq", 32'(irq), 32'd1);
        wr(A_CTRL, 32'h1);
        rd(A_CTRL, q);
        chk("t4_err_held", 32'(q[31]), 32'd1);
        chk("t4_no_rst", 32'(prog_rst), 32'd0);
        wr(A_CTRL, 32'h2);
        rd(A_CTRL, q);
        chk("t4_ctrl_after_abort", q, 32'h0);
        chk("t4_irq_after_abort", 32'(irq), 32'd0);

        // Abort mid-LOAD.
        wr(A_LEN, 32'd64);
        words_q = '{$urandom, $urandom};
        clear_mon();
        wr(A_DATA, words_q[0]);
        wr(A_DATA, words_q[1]);
        wr(A_CTRL, 32'h1);
        wait_chunks(5, "t5_chunks");
        wr(A_CTRL, 32'h2);
        chk("t5_we_after_abort", 32'(prog_we), 32'd0);
        chk("t5_rst_after_abort", 32'(prog_rst), 32'd0);
        rd(A_CTRL, q);
        chk("t5_state", 32'(q[29:28]), 32'd0);
        chk("t5_level", 32'(q[27:16]), 32'd0);
        rd(A_LEN, q);
        chk("t5_len_kept", q, 32'd64);

        // Synchronous reset pulse during LOAD.
        clear_mon();
        wr(A_DATA, $urandom);
        wr(A_DATA, $urandom);
        wr(A_CTRL, 32'h1);
        wait_chunks(3, "t6_chunks");
        @(negedge clk) rst_n = 1'b0;
        @(posedge clk); #1;
        chk("t6_outputs", 32'({ack, prog_rst, prog_we, prog_done, irq, prog_din}), 32'h0);
        chk("t6_dat_o", dat_o, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        rd(A_LEN, q);
        chk("t6_len", q, 32'h0);
        rd(A_CTRL, q);
        chk("t6_ctrl", q, 32'h0);

        // Randomized bitstreams and lengths.
        for (int it = 0; it < 4; it++) begin
            n = $urandom_range(1, 6);
            len = $urandom_range(1, n * CPW);
            words_q.delete();
            for (int i = 0; i < n; i++) words_q.push_back($urandom);
            wr(A_CTRL, 32'h2);
            wr(A_LEN, 32'(len));
            clear_mon();
            for (int i = 0; i < n && i < 4; i++) wr(A_DATA, words_q[i]);
            wr(A_CTRL, 32'h1);
            for (int i = 4; i < n; i++) wb_xfer(A_DATA, 1'b1, words_q[i], q, a);
            wait_done($sformatf("rnd%0d_done", it));
            wait_cycles(3);
            check_stream($sformatf("rnd%0d", it), len);
            rd(A_COUNT, q);
            chk($sformatf("rnd%0d_count", it), q, 32'(len));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
